// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// State encoding, bytes per word and address stride between words.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        CSUM,
        FIN
    } state_t;

    localparam int          WORD_BYTES = 4;
    localparam logic [63:0] ADDR_STEP  = 64'd4;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs bytes little-endian into a 32-bit word; lane 0 lands in bits [7:0].
// Latency: word/word_full are combinational with the 4th strobe; no backpressure.
import imem_loader_pkg::*;

module imem_byte_packer (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        clear,
    input  logic        strobe,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0]  lane;
    logic [31:0] acc;

    // Merge the incoming byte so the full word is visible on the 4th strobe.
    always_comb begin
        word = acc;
        if (strobe) begin
            word[{lane, 3'b000} +: 8] = byte_in;
        end
    end

    assign word_full = strobe && (lane == 2'(WORD_BYTES - 1));

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            lane <= 2'd0;
            acc  <= 32'd0;
        end else if (clear) begin
            lane <= 2'd0;
            acc  <= 32'd0;
        end else if (strobe) begin
            lane <= lane + 2'd1;
            acc  <= word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory writer; holds the CPU while loading.
// Latency: wr_en one cycle after the 4th byte of a word; in_ready low outside LOAD/CSUM.
// Optional IMEM_LOADER_CHECKSUM_EN: trailing two's-complement checksum byte.
import imem_loader_pkg::*;

module imem_loader #(
    parameter int          MAX_WORDS = 64,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        start,
    input  logic [15:0] num_words,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [63:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    state_t      state, state_nxt;
    logic [15:0] words_q;
    logic [15:0] word_idx;
    logic        start_ok;
    logic        over_cap;
    logic        range_bad;
    logic        byte_hs;
    logic        last_word;
    logic [31:0] word;
    logic        word_full;

    assign start_ok  = (state == IDLE) && start;
    assign over_cap  = int'(num_words) > MAX_WORDS;
    assign range_bad = (num_words == 16'd0) || over_cap;
    assign byte_hs   = in_valid && in_ready && (state == LOAD);
    assign last_word = (word_idx + 16'd1) == words_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic       csum_hs;
    assign csum_hs = in_valid && in_ready && (state == CSUM);
`endif

    imem_byte_packer u_packer (
        .CLK       (CLK),
        .resetl    (resetl),
        .clear     (start_ok),
        .strobe    (byte_hs),
        .byte_in   (in_data),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = range_bad ? FIN : LOAD;
            LOAD:  if (word_full) state_nxt = WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            WRITE: state_nxt = last_word ? CSUM : LOAD;
            CSUM:  if (csum_hs) state_nxt = FIN;
`else
            WRITE: state_nxt = last_word ? FIN : LOAD;
`endif
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == LOAD) || (state == CSUM);
        wr_en    = (state == WRITE);
        busy     = (state != IDLE);
        cpu_hold = (state != IDLE);
        done     = (state == FIN);
    end

    // wr_addr/wr_data load with the completing byte so they are stable during WRITE.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            words_q  <= 16'd0;
            word_idx <= 16'd0;
            wr_addr  <= 64'd0;
            wr_data  <= 32'd0;
            err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum      <= 8'd0;
`endif
        end else begin
            if (start_ok) begin
                words_q  <= num_words;
                word_idx <= 16'd0;
                err      <= over_cap;
            end
            if (word_full) begin
                wr_data <= word;
                wr_addr <= BASE_ADDR + ADDR_STEP * 64'(word_idx);
            end
            if (state == WRITE) begin
                word_idx <= word_idx + 16'd1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (start_ok) begin
                sum <= 8'd0;
            end else if (byte_hs) begin
                sum <= sum + in_data;
            end
            if (csum_hs && (in_data != 8'(~sum + 8'd1))) begin
                err <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with a word-list reference model.
module tb_imem_loader;

    localparam int MAXW = 64;

    logic        CLK = 1'b0;
    logic        resetl = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_words = 16'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready, wr_en, busy, cpu_hold, done, err;
    logic [63:0] wr_addr;
    logic [31:0] wr_data;

    int checks = 0;
    int failures = 0;

    imem_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(64'h0)) dut (
        .CLK       (CLK),
        .resetl    (resetl),
        .start     (start),
        .num_words (num_words),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    logic [7:0]  stim[$];
    logic [63:0] got_addr[$];
    logic [31:0] got_data[$];
    int          data_left = 0;
    int          byte_in_word = 0;
    bit          exp_wr = 1'b0;
    bit          mon_en = 1'b0;
    bit          bp = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Capture writes and check write timing from the byte handshakes seen so far.
    always @(negedge CLK) begin
        if (wr_en) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
        end
        if (mon_en) begin
            check("wr_en_timing", 64'(wr_en), 64'(exp_wr));
            check("cpu_hold_eq_busy", 64'(cpu_hold), 64'(busy));
            if (wr_en) check("in_ready_in_write", 64'(in_ready), 64'd0);
            exp_wr = 1'b0;
            if (in_valid && in_ready && data_left > 0) begin
                data_left--;
                byte_in_word = (byte_in_word + 1) % 4;
                if (byte_in_word == 0) exp_wr = 1'b1;
            end
        end
    end

    task automatic fill(input int n);
        stim.delete();
        for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
    endtask

    task automatic pulse_start(input logic [15:0] n);
        start = 1'b1;
        num_words = n;
        @(posedge CLK); #1;
        start = 1'b0;
        num_words = 16'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        if (bp) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_data = 8'($urandom);
                @(posedge CLK); #1;
            end
        end
        in_valid = 1'b1;
        in_data = b;
        for (k = 0; k < 50; k++) begin
            @(negedge CLK);
            if (in_ready) break;
        end
        check("handshake", 64'(in_ready), 64'd1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        in_data = 8'($urandom);
    endtask

    task automatic run_load(input int n, input bit mid_start, input bit bad_csum);
        logic [7:0]  sum;
        logic [31:0] w;
        bit          seen_done;
        got_addr.delete();
        got_data.delete();
        data_left = 4 * n;
        byte_in_word = 0;
        pulse_start(16'(n));
        check("busy_after_start", 64'(busy), 64'd1);
        check("err_cleared_on_start", 64'(err), 64'd0);
        sum = 8'd0;
        for (int i = 0; i < 4 * n; i++) begin
            send_byte(stim[i]);
            sum = sum + stim[i];
            if (mid_start && i == 0) pulse_start(16'(n + 3));
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(bad_csum ? 8'(~sum) : 8'(~sum + 8'd1));
`endif
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (done) begin
                seen_done = 1'b1;
                break;
            end
        end
        check("done_seen", 64'(seen_done), 64'd1);
        check("err_at_done", 64'(err), 64'(bad_csum));
        @(posedge CLK); #1;
        check("done_single_cycle", 64'(done), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
        check("write_count", 64'(got_addr.size()), 64'(n));
        for (int i = 0; i < n && i < got_addr.size(); i++) begin
            w = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
            check("wr_addr", got_addr[i], 64'(4 * i));
            check("wr_data", 64'(got_data[i]), 64'(w));
        end
    endtask

    initial begin
        #2;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", wr_addr, 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cpu_hold", 64'(cpu_hold), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        repeat (2) @(posedge CLK);
        #1 resetl = 1'b1;
        mon_en = 1'b1;

        // Directed two-word load from the example stream.
        stim = '{8'hE9, 8'h03, 8'h40, 8'hF8, 8'hEA, 8'h83, 8'h40, 8'hF8};
        run_load(2, 1'b0, 1'b0);
        check("ex_word0", 64'(got_data[0]), 64'h0000_0000_F840_03E9);
        check("ex_word1", 64'(got_data[1]), 64'h0000_0000_F840_83EA);

        // Random data under random source stalls.
        bp = 1'b1;
        fill(3);
        run_load(3, 1'b0, 1'b0);

        // Zero-length load.
        got_addr.delete();
        pulse_start(16'd0);
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd1);
        check("zero_err", 64'(err), 64'd0);
        @(posedge CLK); #1;
        check("zero_idle", 64'(busy), 64'd0);
        check("zero_no_write", 64'(got_addr.size()), 64'd0);

        // Over-capacity load.
        pulse_start(16'(MAXW + 1));
        check("over_done", 64'(done), 64'd1);
        check("over_err", 64'(err), 64'd1);
        @(posedge CLK); #1;
        check("over_err_sticky", 64'(err), 64'd1);
        check("over_no_write", 64'(got_addr.size()), 64'd0);

        // start during LOAD is ignored; also clears the prior err on its own start.
        fill(2);
        run_load(2, 1'b1, 1'b0);

        // Abandon a load after two bytes with reset.
        fill(1);
        data_left = 4;
        byte_in_word = 0;
        pulse_start(16'd1);
        send_byte(8'hAA);
        send_byte(8'h55);
        mon_en = 1'b0;
        resetl = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_wr_addr", wr_addr, 64'd0);
        check("mid_rst_wr_data", 64'(wr_data), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_cpu_hold", 64'(cpu_hold), 64'd0);
        check("mid_rst_err", 64'(err), 64'd0);
        @(posedge CLK); #1;
        resetl = 1'b1;
        data_left = 0;
        byte_in_word = 0;
        exp_wr = 1'b0;
        mon_en = 1'b1;
        run_load(1, 1'b0, 1'b0);

        // Full-capacity load.
        bp = 1'b0;
        fill(MAXW);
        run_load(MAXW, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        stim = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(1, 1'b0, 1'b0);
        run_load(1, 1'b0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
